// File: rtl/fc_wr_pkg.sv
// Shared types and constants for the FullConnect write arbiter.
package fc_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // log2 of the bytes per beat; turns cnt*BYTES into a shift
  function automatic int byte_shift(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/fc_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module fc_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW:0] j;

  // scan N slots starting at ptr; the first hit wins
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = 0; i < N; i++) begin
      j = {1'b0, ptr} + (PW+1)'(i);
      if (j >= (PW+1)'(N)) j = j - (PW+1)'(N);
      if (!any && req[j[PW-1:0]]) begin
        any             = 1'b1;
        gnt[j[PW-1:0]]  = 1'b1;
        idx             = j[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/fc_write_arbiter.sv
// Shares one Avalon-MM write master between NUM_REQ write buffers, round-robin.
module fc_write_arbiter
  import fc_wr_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int AvalonData_WIDTH = 512,
  parameter int ADDR_WIDTH       = 32,
  parameter int CNT_WIDTH        = 16,
  parameter int REGION_SHIFT     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  Start_i,
  input  logic [ADDR_WIDTH-1:0]                 BaseAddr_i,
  input  logic [CNT_WIDTH-1:0]                  WordCount_i,
  output logic                                  Busy_o,
  output logic                                  Done_o,
  input  logic [NUM_REQ-1:0]                    ReqValid_i,
  input  logic [NUM_REQ*AvalonData_WIDTH-1:0]   ReqData_i,
  output logic [NUM_REQ-1:0]                    ReqAck_o,
  output logic [ADDR_WIDTH-1:0]                 Address_o,
  output logic [AvalonData_WIDTH-1:0]           WriteData_o,
  output logic                                  Write_o,
  input  logic                                  WaitRequest_i
);

  localparam int PW  = $clog2(NUM_REQ);
  localparam int BSH = byte_shift(AvalonData_WIDTH);

  state_t                            state, state_nxt;
  logic [PW-1:0]                     ptr;
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0]             base;
  logic [CNT_WIDTH-1:0]              wc;

  logic [NUM_REQ-1:0] eligible, gnt;
  logic [PW-1:0]      gidx;
  logic               any, slot_open, grant, accept, all_done, start_acc;
  logic [ADDR_WIDTH-1:0] addr_nxt;

  // per-requester eligibility and the all-beats-issued flag
  always_comb begin
    eligible = '0;
    all_done = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible[k] = ReqValid_i[k] && (cnt[k] < wc) && (state == ST_RUN);
      if (cnt[k] != wc) all_done = 1'b0;
    end
  end

  fc_rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .req (eligible),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  // a new beat may be issued when the output register is empty or draining now
  assign accept    = Write_o && !WaitRequest_i;
  assign slot_open = !Write_o || !WaitRequest_i;
  assign grant     = slot_open && any;
  assign ReqAck_o  = grant ? gnt : '0;
  assign start_acc = Start_i && (state == ST_IDLE);
  assign addr_nxt  = base + (ADDR_WIDTH'(gidx) << REGION_SHIFT)
                          + (ADDR_WIDTH'(cnt[gidx]) << BSH);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next state and status outputs
  always_comb begin
    state_nxt = state;
    Busy_o    = 1'b0;
    Done_o    = 1'b0;
    case (state)
      ST_IDLE: if (Start_i) state_nxt = ST_RUN;
      ST_RUN: begin
        Busy_o = 1'b1;
        if (all_done && (!Write_o || accept)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        Done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // config latch, beat counters, RR pointer and the held Avalon write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      cnt         <= '0;
      base        <= '0;
      wc          <= '0;
      Address_o   <= '0;
      WriteData_o <= '0;
      Write_o     <= 1'b0;
    end else begin
      if (start_acc) begin
        base <= BaseAddr_i;
        wc   <= WordCount_i;
        cnt  <= '0;
      end
      if (grant) begin
        Write_o     <= 1'b1;
        Address_o   <= addr_nxt;
        WriteData_o <= ReqData_i[int'(gidx)*AvalonData_WIDTH +: AvalonData_WIDTH];
        cnt[gidx]   <= cnt[gidx] + 1'b1;
        ptr         <= (gidx == PW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
      end else if (accept) begin
        Write_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fc_write_arbiter.sv
// Scoreboard bench for fc_write_arbiter: a spec-level model predicts acks and beats.
module tb_fc_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 512;

  typedef struct {
    logic [31:0]   addr;
    logic [DW-1:0] data;
    int            req;
  } beat_t;

  logic            clk = 0, rst = 0;
  logic            Start_i = 0;
  logic [31:0]     BaseAddr_i = '0;
  logic [15:0]     WordCount_i = '0;
  logic            Busy_o, Done_o;
  logic [N-1:0]    ReqValid_i = '0;
  logic [N*DW-1:0] ReqData_i;
  logic [N-1:0]    ReqAck_o;
  logic [31:0]     Address_o;
  logic [DW-1:0]   WriteData_o;
  logic            Write_o;
  logic            WaitRequest_i = 0;

  fc_write_arbiter #(.NUM_REQ(N), .AvalonData_WIDTH(DW), .ADDR_WIDTH(32),
                     .CNT_WIDTH(16), .REGION_SHIFT(16)) dut (
    .clk(clk), .rst(rst), .Start_i(Start_i), .BaseAddr_i(BaseAddr_i),
    .WordCount_i(WordCount_i), .Busy_o(Busy_o), .Done_o(Done_o),
    .ReqValid_i(ReqValid_i), .ReqData_i(ReqData_i), .ReqAck_o(ReqAck_o),
    .Address_o(Address_o), .WriteData_o(WriteData_o), .Write_o(Write_o),
    .WaitRequest_i(WaitRequest_i)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // buffer contents: a fresh word is loaded after each ack
  logic [15:0] seq [N];
  logic        bump [N];
  initial for (int k = 0; k < N; k++) begin seq[k] = 16'(k * 256); bump[k] = 0; end
  always_comb begin
    ReqData_i = '0;
    for (int k = 0; k < N; k++) ReqData_i[k*DW +: DW] = {16{8'(k), 8'h5A, seq[k]}};
  end
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int k = 0; k < N; k++) if (bump[k]) begin seq[k]++; bump[k] = 0; end
  end

  // model state
  int          m_st = 0;           // 0 idle, 1 run, 2 done
  int          m_cnt [N];
  int          m_ptr = 0, m_wc = 0;
  logic [31:0] m_base = '0;
  logic        m_wr = 0;
  beat_t       sb [$];
  int          ack_log [$];
  logic [31:0] acc_addr [$];
  int          acc_cyc [$];
  int          done_cyc = -1, stall_cnt = 0, wr_cnt = 0;
  initial for (int k = 0; k < N; k++) m_cnt[k] = 0;

  always @(negedge clk) begin
    int eg;
    logic alldone, acc;
    beat_t b;
    if (rst) begin
      m_st = 0; m_ptr = 0; m_wr = 0; m_wc = 0; m_base = '0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      sb.delete();
    end else begin
      chk("busy", Busy_o, m_st == 1);
      chk("done", Done_o, m_st == 2);
      chk("write", Write_o, m_wr);
      if (Done_o && done_cyc < 0) done_cyc = cyc;
      if (Write_o) wr_cnt++;
      eg = -1;
      if (m_st == 1 && (!m_wr || !WaitRequest_i))
        for (int i = 0; i < N; i++) begin
          int j;
          j = (m_ptr + i) % N;
          if (eg < 0 && ReqValid_i[j] && m_cnt[j] < m_wc) eg = j;
        end
      chk("ack", ReqAck_o, (eg >= 0) ? (N'(1) << eg) : '0);
      for (int k = 0; k < N; k++) if (ReqAck_o[k]) ack_log.push_back(k);
      if (m_wr) begin
        if (sb.size() == 0) chk("sb_empty", 1, 0);
        else begin
          chk("addr", Address_o, sb[0].addr);
          chk("wdata", WriteData_o, sb[0].data);
          if (WaitRequest_i) stall_cnt++;
          else begin
            acc_addr.push_back(Address_o);
            acc_cyc.push_back(cyc);
            void'(sb.pop_front());
          end
        end
      end
      acc = m_wr && !WaitRequest_i;
      alldone = 1;
      for (int k = 0; k < N; k++) if (m_cnt[k] != m_wc) alldone = 0;
      case (m_st)
        0: if (Start_i) begin
             m_st = 1; m_base = BaseAddr_i; m_wc = int'(WordCount_i);
             for (int k = 0; k < N; k++) m_cnt[k] = 0;
           end
        1: if (alldone && (!m_wr || acc)) m_st = 2;
        default: m_st = 0;
      endcase
      if (eg >= 0) begin
        b.addr = m_base + (32'(eg) << 16) + 32'(m_cnt[eg] * (DW / 8));
        b.data = ReqData_i[eg*DW +: DW];
        b.req  = eg;
        sb.push_back(b);
        m_cnt[eg]++;
        m_ptr = (eg + 1) % N;
        m_wr = 1;
        bump[eg] = 1;
      end else if (acc) m_wr = 0;
    end
  end

  task automatic clr_logs();
    ack_log.delete(); acc_addr.delete(); acc_cyc.delete();
    done_cyc = -1; stall_cnt = 0; wr_cnt = 0;
  endtask

  task automatic start(input logic [31:0] base, input logic [15:0] wc, output int scyc);
    @(posedge clk); #1;
    BaseAddr_i = base; WordCount_i = wc; Start_i = 1; scyc = cyc;
    @(posedge clk); #1;
    Start_i = 0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n;
    logic got;
    got = 0; n = 0;
    while (n < max && !got) begin
      @(negedge clk);
      if (Done_o) got = 1;
      n++;
    end
    chk(tag, got, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
  endtask

  int sc;

  initial begin
    // reset state
    rst = 1; #1;
    chk("rst_write", Write_o, 0); chk("rst_busy", Busy_o, 0);
    chk("rst_done", Done_o, 0); chk("rst_ack", ReqAck_o, 0);
    chk("rst_addr", Address_o, 0);
    #20; do_reset();

    // 1: full-rate round robin
    clr_logs(); ReqValid_i = '1;
    start(32'h1000_0000, 16'd2, sc);
    wait_done("t1_done", 40);
    chk("t1_beats", acc_addr.size(), 8);
    chk("t1_acks", ack_log.size(), 8);
    for (int i = 0; i < 8 && i < acc_addr.size() && i < ack_log.size(); i++) begin
      chk("t1_order", ack_log[i], i % 4);
      chk("t1_addr", acc_addr[i], 32'h1000_0000 + (32'(i % 4) << 16) + 32'((i / 4) * 64));
      chk("t1_rate", acc_cyc[i], acc_cyc[0] + i);
    end
    if (acc_cyc.size() == 8) chk("t1_done_lat", done_cyc, acc_cyc[7] + 1);

    // 2: three-cycle stall on beat 1
    clr_logs();
    start(32'h1000_0000, 16'd2, sc);
    @(posedge clk); #1;
    @(posedge clk); #1; WaitRequest_i = 1;
    repeat (3) @(posedge clk);
    #1; WaitRequest_i = 0;
    wait_done("t2_done", 40);
    chk("t2_beats", acc_addr.size(), 8);
    chk("t2_stall", stall_cnt, 3);
    if (acc_addr.size() > 1) chk("t2_addr1", acc_addr[1], 32'h1001_0000);

    // 4: zero-length pass, then Start while busy
    clr_logs();
    start(32'h1000_0000, 16'd0, sc);
    wait_done("t4_done", 10);
    chk("t4_done_lat", done_cyc - sc, 2);
    chk("t4_nowrite", wr_cnt, 0);
    clr_logs();
    start(32'h1000_0000, 16'd2, sc);
    @(posedge clk); #1;
    BaseAddr_i = 32'h2000_0000; WordCount_i = 16'd5; Start_i = 1;
    @(posedge clk); #1; Start_i = 0;
    wait_done("t4b_done", 40);
    chk("t4b_beats", acc_addr.size(), 8);
    if (acc_addr.size() == 8) chk("t4b_last", acc_addr[7], 32'h1003_0040);

    // 5: address wrap
    clr_logs();
    start(32'hFFFF_FFC0, 16'd2, sc);
    wait_done("t5_done", 40);
    if (acc_addr.size() > 4) begin
      chk("t5_a0", acc_addr[0], 32'hFFFF_FFC0);
      chk("t5_a4", acc_addr[4], 32'h0000_0000);
    end else chk("t5_beats", acc_addr.size(), 8);

    // 3: single requester, quota reached, pass never completes
    clr_logs(); ReqValid_i = 4'b0100;
    start(32'h1000_0000, 16'd3, sc);
    repeat (14) @(posedge clk);
    #1;
    chk("t3_beats", acc_addr.size(), 3);
    for (int i = 0; i < 3 && i < acc_addr.size(); i++)
      chk("t3_addr", acc_addr[i], 32'h1002_0000 + 32'(i * 64));
    chk("t3_nodone", done_cyc, -1);
    chk("t3_busy", Busy_o, 1);
    do_reset();

    // 6: reset during a stalled write, then a fresh pass
    clr_logs(); ReqValid_i = '1; WaitRequest_i = 1;
    start(32'h1000_0000, 16'd2, sc);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_pre_write", Write_o, 1);
    rst = 1; #1;
    chk("t6_rst_write", Write_o, 0);
    chk("t6_rst_busy", Busy_o, 0);
    @(posedge clk); #1; rst = 0; WaitRequest_i = 0;
    clr_logs();
    start(32'h1000_0000, 16'd1, sc);
    wait_done("t6_done", 20);
    chk("t6_beats", acc_addr.size(), 4);
    for (int i = 0; i < 4 && i < acc_addr.size(); i++)
      chk("t6_addr", acc_addr[i], 32'h1000_0000 + (32'(i) << 16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
